// File: rtl/spi_bus_bridge.sv
// SPI command layer: decodes header/address/data bytes from spi_slave into byte-wide bus cycles.
// Optional bus-cycle timeout is enabled with the SPI_BRIDGE_TIMEOUT_EN macro.
module spi_bus_bridge #(
   parameter int unsigned ADDR_BYTES  = 3,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                    clk6x,
   input  logic                    resetn,
   input  logic [7:0]              rx_byte_i,
   input  logic                    rx_hdr_en_i,
   input  logic                    rx_db_en_i,
   output logic [7:0]              tx_byte_o,
   output logic                    tx_en_o,
   output logic                    bus_req_o,
   output logic                    bus_we_o,
   output logic [8*ADDR_BYTES-1:0] bus_addr_o,
   output logic [7:0]              bus_wdata_o,
   input  logic [7:0]              bus_rdata_i,
   input  logic                    bus_ack_i,
   output logic                    busy_o,
   output logic                    overrun_o,
   output logic                    timeout_o
);
   localparam int unsigned AW = 8 * ADDR_BYTES;
   localparam int unsigned CW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

   typedef enum logic [2:0] {
      StIdle, StAddr, StWdata, StBusWr, StBusRd, StRdata, StIgnore
   } state_e;

   state_e          r_state;
   logic [AW-1:0]   r_addr;
   logic [CW-1:0]   r_acnt;
   logic            r_rd;
   logic            r_req;
   logic            r_we;
   logic [7:0]      r_wdata;
   logic [7:0]      r_tx_byte;
   logic            r_tx_en;
   logic            r_overrun;
   logic            r_pend;
   logic [3:0]      r_pend_op;
   logic            w_done;
   logic [7:0]      w_rdata;
   logic            w_timeout;
   logic            w_dec;
   logic [3:0]      w_op;

`ifdef SPI_BRIDGE_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_tocnt;
   logic          r_timeout;
   logic          w_to;

   assign w_to      = r_req && !bus_ack_i && (r_tocnt == TW'(TIMEOUT_CYC - 1));
   assign w_done    = r_req && (bus_ack_i || w_to);
   assign w_rdata   = w_to ? 8'hFF : bus_rdata_i;
   assign w_timeout = r_timeout;

   always_ff @(posedge clk6x or negedge resetn) begin
      if (!resetn) begin
         r_tocnt   <= '0;
         r_timeout <= 1'b0;
      end else begin
         // A timeout in the same cycle as a header survives into the next status report
         if (w_to)             r_timeout <= 1'b1;
         else if (rx_hdr_en_i) r_timeout <= 1'b0;
         r_tocnt <= (r_req && !w_done) ? r_tocnt + TW'(1) : '0;
      end
   end
`else
   assign w_done    = r_req && bus_ack_i;
   assign w_rdata   = bus_rdata_i;
   assign w_timeout = 1'b0;
`endif

   // Decode a fresh header unless a bus cycle is still outstanding, else a latched one once idle
   assign w_dec = rx_hdr_en_i ? !(r_req && !w_done) : (r_pend && !r_req);
   assign w_op  = rx_hdr_en_i ? rx_byte_i[3:0] : r_pend_op;

   always_ff @(posedge clk6x or negedge resetn) begin
      if (!resetn) begin
         r_state   <= StIdle;
         r_addr    <= '0;
         r_acnt    <= '0;
         r_rd      <= 1'b0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_wdata   <= 8'h00;
         r_tx_byte <= 8'h00;
         r_tx_en   <= 1'b0;
         r_overrun <= 1'b0;
         r_pend    <= 1'b0;
         r_pend_op <= 4'h0;
      end else begin
         r_tx_en <= 1'b0;
         if (rx_hdr_en_i) begin
            r_tx_byte <= {6'b0, w_timeout, r_overrun};
            r_tx_en   <= 1'b1;
            r_overrun <= 1'b0;
         end
         if (w_dec) begin
            r_state <= (w_op == 4'h1 || w_op == 4'h2) ? StAddr : StIgnore;
            r_rd    <= (w_op == 4'h2);
            r_acnt  <= '0;
            r_req   <= 1'b0;
            r_pend  <= 1'b0;
         end else if (rx_hdr_en_i) begin
            r_pend    <= 1'b1;
            r_pend_op <= rx_byte_i[3:0];
         end else begin
            unique case (r_state)
               StAddr: if (rx_db_en_i) begin
                  r_addr <= (r_addr << 8) | AW'(rx_byte_i);
                  r_acnt <= r_acnt + CW'(1);
                  if (r_acnt == CW'(ADDR_BYTES - 1)) begin
                     if (r_rd) begin
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= StBusRd;
                     end else begin
                        r_state <= StWdata;
                     end
                  end
               end
               StWdata: if (rx_db_en_i) begin
                  r_wdata <= rx_byte_i;
                  r_we    <= 1'b1;
                  r_req   <= 1'b1;
                  r_state <= StBusWr;
               end
               StBusWr, StBusRd: begin
                  if (rx_db_en_i) r_overrun <= 1'b1;
                  if (w_done) begin
                     r_req <= 1'b0;
                     if (!r_pend) begin
                        r_addr <= r_addr + AW'(1);
                        if (r_state == StBusRd) begin
                           r_tx_byte <= w_rdata;
                           r_tx_en   <= 1'b1;
                           r_state   <= StRdata;
                        end else begin
                           r_state <= StWdata;
                        end
                     end
                  end
               end
               StRdata: if (rx_db_en_i) begin
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_state <= StBusRd;
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_byte_o   = r_tx_byte;
   assign tx_en_o     = r_tx_en;
   assign bus_req_o   = r_req;
   assign bus_we_o    = r_we;
   assign bus_addr_o  = r_addr;
   assign bus_wdata_o = r_wdata;
   assign busy_o      = (r_state != StIdle) && (r_state != StIgnore);
   assign overrun_o   = r_overrun;
   assign timeout_o   = w_timeout;
endmodule
